// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: one-hot state codes and
// default sizing.
package seq_pkg;

    localparam int STATE_W   = 4;
    localparam int DEF_PAT_W = 8;
    localparam int DEF_REP_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_GAP   = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable pattern register with a bit-index down-counter that reloads to
// len-1 after the last bit, so repetitions need no extra load cycle.
module seq_gen_shreg
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             bit_o,
    output logic             last_o
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;

    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        idx_d = idx_q;
        if (load_i) begin
            pat_d = pat_i;
            len_d = len_i;
            idx_d = (len_i == '0) ? '0 : len_i - LEN_W'(1);
        end else if (adv_i) begin
            // The reload at index 0 keeps idx from ever wrapping below zero.
            idx_d = (idx_q == '0) ? len_q - LEN_W'(1) : idx_q - LEN_W'(1);
        end
    end

    // Mux by compare avoids an index wider than the pattern's address range.
    always_comb begin
        bit_o = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (idx_q == LEN_W'(i)) bit_o = pat_q[i];
        end
    end

    assign last_o = (idx_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends pat MSB-first (bit len-1 first), reps+1 times.
// Define SEQ_GEN_GAP_EN to insert one idle bit between repetitions.
module seq_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int REP_W = DEF_REP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PAT_W-1:0]   pat,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   reps,
    output logic               dout,
    output logic               dvalid,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] dbg_state
);

    // Handshake: start is sampled only in IDLE and never queued; busy rises the
    // cycle after start and falls while done pulses; abort (priority over
    // start) returns to IDLE without done; all outputs change on posedge only.

    state_e           state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             empty_q, empty_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_clamped;
    logic             load;
    logic             adv;
    logic             cur_bit;
    logic             last_bit;

    assign len_clamped = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    assign load        = (state_q == ST_IDLE) && start && !abort;
    assign adv         = (state_q == ST_SHIFT) && !abort;

    seq_gen_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .adv_i  (adv),
        .pat_i  (pat),
        .len_i  (len_clamped),
        .bit_o  (cur_bit),
        .last_o (last_bit)
    );

    always_comb begin
        state_d  = state_q;
        rep_d    = rep_q;
        empty_d  = empty_q;
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (state_q != ST_IDLE && abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        rep_d = reps;
                        if (len_clamped == '0) begin
                            empty_d = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            empty_d = 1'b0;
                            state_d = ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    dout_d   = cur_bit;
                    dvalid_d = 1'b1;
                    busy_d   = 1'b1;
                    if (last_bit) begin
                        if (rep_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            rep_d = rep_q - REP_W'(1);
`ifdef SEQ_GEN_GAP_EN
                            state_d = ST_GAP;
`else
                            state_d = ST_SHIFT;
`endif
                        end
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                ST_GAP: begin
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
`endif
                ST_DONE: begin
                    // An empty send never saw SHIFT, so busy shares its one cycle with done.
                    done_d  = 1'b1;
                    busy_d  = empty_q;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rep_q    <= '0;
            empty_q  <= 1'b0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rep_q    <= rep_d;
            empty_q  <= empty_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dout      = dout_q;
    assign dvalid    = dvalid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: expected bits/done cycles are queued at start,
// a negedge monitor pops and compares whenever dvalid or done is presented.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pat = '0;
    logic [3:0] len = '0;
    logic [3:0] reps = '0;
    logic       dout, dvalid, busy, done;
    logic [3:0] dbg_state;

    seq_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pat       (pat),
        .len       (len),
        .reps      (reps),
        .dout      (dout),
        .dvalid    (dvalid),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];       // {cycle, bit}
    logic [31:0] exp_done_q[$];  // cycle of done pulse

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        logic [31:0] d;
        if (dvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_dvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bit_cycle", cyc, e[32:1]);
                chk("bit_value", {31'd0, dout}, {31'd0, e[0]});
            end
        end
        if (done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                d = exp_done_q.pop_front();
                chk("done_cycle", cyc, d);
            end
        end
    end

    // Loopback 0110 detector sampling dout on negedge like the real detectors.
    logic [2:0] det_sh = '0;
    logic       det_hit = 1'b0;
    always @(negedge clk) begin
        if (dvalid === 1'b1) begin
            if ({det_sh, dout} == 4'b0110) det_hit <= 1'b1;
            det_sh <= {det_sh[1:0], dout};
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a negedge; returns at the negedge after the start edge n.
    task automatic start_send(input logic [7:0] p, input logic [3:0] l,
                              input logic [3:0] r, output int unsigned n);
        pat   = p;
        len   = l;
        reps  = r;
        start = 1'b1;
        n     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        pat   = 8'($urandom);
        len   = 4'($urandom_range(0, 15));
        reps  = 4'($urandom_range(0, 15));
    endtask

    task automatic push_bits(input logic [7:0] p, input logic [3:0] l,
                             input logic [3:0] r, input int unsigned n, input int limit);
        int          eff;
        int          pushed;
        int unsigned t;
        eff    = (l > 4'd8) ? 8 : int'(l);
        pushed = 0;
        t      = n + 1;
        if (eff == 0) return;
        for (int rr = 0; rr <= int'(r); rr++) begin
            for (int i = eff - 1; i >= 0; i--) begin
                if (pushed < limit) exp_q.push_back({t, p[i]});
                t++;
                pushed++;
            end
`ifdef SEQ_GEN_GAP_EN
            if (rr < int'(r)) t++;
`endif
        end
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] p;
        logic [3:0] l;
        logic [3:0] r;
        int         d;   // done offset from start edge, contiguous
        int         dg;  // done offset with gap bits
    } vec_t;

    vec_t vecs[6];

    // ---------------- test sequence ----------------
    initial begin
        int unsigned n;
        vecs[0] = '{8'h06, 4'd4,  4'd0,  5,  5};
        vecs[1] = '{8'h06, 4'd4,  4'd2,  13, 15};
        vecs[2] = '{8'hA5, 4'd12, 4'd0,  9,  9};   // len clamps to 8
        vecs[3] = '{8'hC3, 4'd8,  4'd1,  17, 18};
        vecs[4] = '{8'h02, 4'd2,  4'd15, 33, 48};  // max reps: 16 sends
        vecs[5] = '{8'h00, 4'd0,  4'd3,  1,  1};   // empty pattern

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_state", {28'd0, dbg_state}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // single send with busy profile: busy N+1..N+4, done with busy low at N+5
        start_send(8'b0000_0110, 4'd4, 4'd0, n);
        push_bits(8'b0000_0110, 4'd4, 4'd0, n, 99);
        exp_done_q.push_back(n + 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("single_done", {31'd0, done}, 32'd1);
        chk("single_busy_low", {31'd0, busy}, 32'd0);

        // back-to-back table: each start issued on the negedge where done is high
        for (int v = 0; v < 6; v++) begin
            start_send(vecs[v].p, vecs[v].l, vecs[v].r, n);
            push_bits(vecs[v].p, vecs[v].l, vecs[v].r, n, 99);
`ifdef SEQ_GEN_GAP_EN
            exp_done_q.push_back(n + vecs[v].dg);
`else
            exp_done_q.push_back(n + vecs[v].d);
`endif
            wait_done(80);
        end

        // empty pattern: busy and done together at N+1, idle at N+2
        @(negedge clk);
        start_send(8'hFF, 4'd0, 4'd0, n);
        exp_done_q.push_back(n + 1);
        @(negedge clk);
        chk("empty_busy", {31'd0, busy}, 32'd1);
        chk("empty_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("empty_idle_busy", {31'd0, busy}, 32'd0);
        chk("empty_idle_done", {31'd0, done}, 32'd0);

        // abort at bit 2 of a 4-bit send
        start_send(8'b0000_1001, 4'd4, 4'd0, n);
        push_bits(8'b0000_1001, 4'd4, 4'd0, n, 2);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_dvalid", {31'd0, dvalid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_state", {28'd0, dbg_state}, 32'h1);
        repeat (6) @(negedge clk);

        // abort wins over start in IDLE
        abort = 1'b1;
        start = 1'b1;
        pat   = 8'hFF;
        len   = 4'd8;
        reps  = 4'd0;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", {31'd0, busy}, 32'd0);
        chk("abort_start_state", {28'd0, dbg_state}, 32'h1);
        repeat (3) @(negedge clk);

        // reset mid-send
        start_send(8'b0000_1011, 4'd4, 4'd1, n);
        push_bits(8'b0000_1011, 4'd4, 4'd1, n, 2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_dout", {31'd0, dout}, 32'd0);
        chk("midrst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_state", {28'd0, dbg_state}, 32'h1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // loopback into a 0110 detector; a start while busy must be ignored
        det_hit = 1'b0;
        det_sh  = '0;
        start_send(8'b0000_0110, 4'd4, 4'd0, n);
        push_bits(8'b0000_0110, 4'd4, 4'd0, n, 99);
        exp_done_q.push_back(n + 5);
        @(negedge clk);
        start = 1'b1;
        pat   = 8'hFF;
        len   = 4'd8;
        reps  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        repeat (4) @(negedge clk);
        chk("loopback_detect", {31'd0, det_hit}, 32'd1);
        chk("ignored_start_idle", {28'd0, dbg_state}, 32'h1);

        chk("exp_bits_drained", exp_q.size(), 32'd0);
        chk("exp_done_drained", exp_done_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial bit-pattern generator: latches an up-to-PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clock, repeating it a programmable number of times. It is the stimulus/transmit side for the serial sequence detectors in this design. It drives their `din` line from `posedge clk` so that data is stable at their `negedge clk` sampling point. A start/busy/done handshake lets a controller or bench chain transmissions back to back.

## Interface
Parameters:
- PAT_W, 8, maximum pattern length in bits (≥2)
- LEN_W, $clog2(PAT_W+1), width of `len`
- REP_W, 4, width of `reps`

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE without `done`
- pat  in  PAT_W  pattern; bit `len-1` is sent first
- len  in  LEN_W  pattern length; 0 = empty; values >PAT_W are clamped to PAT_W
- reps  in  REP_W  extra repetitions; total sends = reps+1
- dout  out  1  serial data, registered
- dvalid  out  1  high while `dout` carries a pattern bit
- busy  out  1  high from the cycle after start until `done`
- done  out  1  one-cycle pulse after the last bit of the last repetition

## Operation
- One-hot FSM with states IDLE, SHIFT, GAP, DONE.
- IDLE: `start`=1 latches `pat`, clamped `len`, and `reps` into internal registers.
  - len≠0: next state SHIFT with bit index = len-1 and repetition counter = reps.
  - len=0: next state DONE; no bits are sent.
- SHIFT: drives `dout=pat_q[idx]`, `dvalid=1`, and decrements idx.
  - At idx=0 with rep counter 0: next state DONE.
  - At idx=0 with rep counter ≠0: decrement rep counter, reload idx=len-1. Next state is GAP if SEQ_GEN_GAP_EN is defined, else SHIFT, so repetitions run back to back.
- GAP: `dout=0`, `dvalid=0` for exactly one cycle, then SHIFT.
- DONE: `done=1` for one cycle, `busy=0`, then IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `pat`, `len`, and `reps` may change freely after the latch cycle without affecting the transfer in progress.
- `abort`=1 in any non-IDLE state: next state IDLE, `dvalid=0`, `dout=0`, `busy=0`, no `done`. If `abort` and `start` are both high in IDLE, `abort` wins and nothing starts.
- Reset mid-transfer behaves like abort, and every register is cleared.
- Counter widths:
  - idx is LEN_W wide and never underflows; the reload is taken at 0.
  - The rep counter is REP_W wide; reps=2^REP_W-1 gives 2^REP_W sends.

## Timing
- Reset values: dout=0, dvalid=0, busy=0, done=0, state=IDLE.
- With `start` sampled at edge N:
  - First bit appears at edge N+1, so latency is 1 cycle.
  - `busy` rises at N+1.
- Without gap, the last bit is at edge N+len·(reps+1), and `done` pulses at the following edge.
- With SEQ_GEN_GAP_EN, add `reps` cycles to that figure.
- len=0: `busy` and `done` are both high at N+1, idle at N+2.
- `busy` falls in the same cycle that `done` is high; a new `start` is accepted at the edge where `done` is high.
- Outputs change only on posedge clk, so they are stable across the detector's negedge.

## Configuration
- SEQ_GEN_GAP_EN defined: one idle bit (dvalid=0, dout=0) is inserted between repetitions, and the GAP state exists.
- SEQ_GEN_GAP_EN undefined: the GAP state and its logic are compiled out, and repetitions are contiguous.
- Single-send behaviour (reps=0) is identical with and without the macro.

## Structure
- The shared package `seq_pkg` holds:
  - the one-hot state encodings (IDLE, SHIFT, GAP, DONE);
  - the state vector width;
  - the default PAT_W and REP_W.
- One sub-module, `seq_gen_shreg`: a loadable PAT_W-bit pattern register with an idx down-counter and reload. It outputs the current bit and a last-bit flag.
- The FSM and the repetition counter stay in `seq_gen`.

## Test plan
- Single send: pat=8'b0000_0110, len=4, reps=0 → dout 0,1,1,0 with dvalid=1 on edges N+1..N+4, done at N+5, busy high N+1..N+4.
- Repeat without gap: pat=4'b0110, len=4, reps=2 → 12 contiguous valid bits 0110 0110 0110, done at N+13.
- Repeat with SEQ_GEN_GAP_EN: same stimulus → a dvalid=0 cycle after bits 4 and 8, done at N+15.
- Boundaries:
  - len=0 → busy and done both pulse at N+1, dvalid never high.
  - len=12 with PAT_W=8 → exactly 8 bits sent.
- Abort/reset:
  - abort at bit 2 of a 4-bit send → dvalid=0 and busy=0 next edge, no done.
  - rst_n=0 mid-send → all outputs 0 at the next edge.
- Loopback: drive the serial detector with dout and send 0110 → the detector's flag asserts; a start pulse while busy is ignored.
